// File: rtl/md_sched_pkg.sv
// Shared op codes, widths and FSM state type for the HI/LO multiply/divide scheduler.
// Defining MD_MADD_EN widens op to 4 bits and adds the MADD/MADDU/MSUB/MSUBU codes.
package md_sched_pkg;

`ifdef MD_MADD_EN
  localparam int unsigned MdOpW = 4;
`else
  localparam int unsigned MdOpW = 3;
`endif

  typedef logic [MdOpW-1:0] md_op_t;
  typedef logic [3:0]       md_cnt_t;

  localparam md_op_t MD_MULT  = 'd0;
  localparam md_op_t MD_MULTU = 'd1;
  localparam md_op_t MD_DIV   = 'd2;
  localparam md_op_t MD_DIVU  = 'd3;
  localparam md_op_t MD_MTHI  = 'd4;
  localparam md_op_t MD_MTLO  = 'd5;
`ifdef MD_MADD_EN
  localparam md_op_t MD_MADD  = 'd6;
  localparam md_op_t MD_MADDU = 'd7;
  localparam md_op_t MD_MSUB  = 'd8;
  localparam md_op_t MD_MSUBU = 'd9;
`endif

  typedef enum logic {StIdle, StRun} md_state_e;

  // Ops that take MULT_CYCLES (plain multiplies and, when built in, accumulates).
  function automatic logic is_mul_op(md_op_t op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage request / HI-LO result bundle between the pipeline and md_sched.
interface md_sched_if;
  import md_sched_pkg::*;

  logic        start;
  md_op_t      op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op, A, B,
    input  busy, hi_out, lo_out
  );

  modport slave (
    input  start, op, A, B,
    output busy, hi_out, lo_out
  );
endinterface

// File: rtl/md_arith.sv
// Combinational HI/LO result for a latched mul/div op; the accumulate path exists
// only when MD_MADD_EN is defined.
module md_arith
  import md_sched_pkg::*;
(
  input  md_op_t      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] next_hi_o,
  output logic [31:0] next_lo_o
);

  logic        signed_op;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
`ifdef MD_MADD_EN
    signed_op = signed_op || (op_i == MD_MADD) || (op_i == MD_MSUB);
`endif
  end

  // The low 64 bits of the product of the extended operands are exact for either signedness.
  assign a_ext   = signed_op ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
  assign b_ext   = signed_op ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
  assign product = a_ext * b_ext;

  // Divide on magnitudes so 0x80000000 / -1 needs no special case.
  assign a_mag = (signed_op && a_i[31]) ? -a_i : a_i;
  assign b_mag = (signed_op && b_i[31]) ? -b_i : b_i;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign q_neg = signed_op && (a_i[31] ^ b_i[31]);
  assign r_neg = signed_op && a_i[31];
  assign quot  = q_neg ? -q_mag : q_mag;
  assign rem   = r_neg ? -r_mag : r_mag;

  always_comb begin
    next_hi_o = hi_i;
    next_lo_o = lo_i;
    case (op_i)
      MD_MULT, MD_MULTU: {next_hi_o, next_lo_o} = product;
      MD_DIV, MD_DIVU: begin
        if (b_i != 32'd0) begin
          next_lo_o = quot;
          next_hi_o = rem;
        end
      end
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU: {next_hi_o, next_lo_o} = {hi_i, lo_i} + product;
      MD_MSUB, MD_MSUBU: {next_hi_o, next_lo_o} = {hi_i, lo_i} - product;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MIPS multiply/divide scheduler owning HI/LO; MD_MADD_EN (see md_sched_pkg)
// adds the multiply-accumulate ops.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);

  localparam md_cnt_t MultCnt = md_cnt_t'(MULT_CYCLES);
  localparam md_cnt_t DivCnt  = md_cnt_t'(DIV_CYCLES);

  md_state_e   state_q;
  md_cnt_t     cnt_q;
  md_op_t      op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic [31:0] next_hi;
  logic [31:0] next_lo;

  md_arith u_arith (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .next_hi_o(next_hi),
    .next_lo_o(next_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (is_mul_op(bus.op) || is_div_op(bus.op)) begin
              op_q    <= bus.op;
              a_q     <= bus.A;
              b_q     <= bus.B;
              cnt_q   <= is_div_op(bus.op) ? DivCnt : MultCnt;
              state_q <= StRun;
              busy_q  <= 1'b1;
            end else if (bus.op == MD_MTHI) begin
              hi_q <= bus.A;
            end else if (bus.op == MD_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end
        StRun: begin
          // start is deliberately not looked at here: a request mid-run is dropped.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            hi_q    <= next_hi;
            lo_q    <= next_lo;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Randomised scoreboard bench for md_sched: a driver pushes expected HI/LO and busy length,
// a negedge monitor pops and compares when each result is due.
module tb_md_sched;
  import md_sched_pkg::*;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  typedef struct {
    int          due;
    int          len;  // -1 skips the busy-length check
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   next_free = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  exp_t sb[$];

  md_sched_if bus ();

  md_sched #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: architectural HI/LO effect of one accepted op; returns busy length.
  task automatic model_apply(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                             output int n);
    longint      sa;
    longint      sbv;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    n   = 0;
    case (o)
      MD_MULT: begin
        p = sa * sbv;
        {m_hi, m_lo} = p;
        n = MultN;
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p;
        n = MultN;
      end
      MD_DIV: begin
        if (b != 0) begin
          q = sa / sbv;
          r = sa % sbv;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
        n = DivN;
      end
      MD_DIVU: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
        n = DivN;
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic wait_free();
    while (cyc < next_free) @(negedge clk);
  endtask

  task automatic issue(input string name, input md_op_t o, input logic [31:0] a,
                       input logic [31:0] b);
    int   n;
    exp_t e;
    wait_free();
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    model_apply(o, a, b, n);
    e.due  = cyc + 1 + n;
    e.len  = n;
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.name = name;
    sb.push_back(e);
    next_free = cyc + 1 + n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // A request the DUT must drop (issued while busy).
  task automatic poke(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic expect_reset_state(input string name);
    exp_t e;
    m_hi   = '0;
    m_lo   = '0;
    e.due  = cyc + 1;
    e.len  = -1;
    e.hi   = '0;
    e.lo   = '0;
    e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy === 1'b1) run_len++;
    if (sb.size() > 0 && cyc >= sb[0].due) begin
      e = sb.pop_front();
      if (cyc != e.due) begin
        checks++;
        errors++;
        $display("FAIL %s: result slot missed at cycle %0d, required cycle %0d", e.name, cyc,
                 e.due);
      end else begin
        check({e.name, " busy"}, {31'd0, bus.busy}, 32'd0);
        if (e.len >= 0) check({e.name, " busy_len"}, 32'(run_len), 32'(e.len));
        check({e.name, " hi"}, bus.hi_out, e.hi);
        check({e.name, " lo"}, bus.lo_out, e.lo);
      end
      run_len = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d results outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    md_op_t      o;
    logic [31:0] a;
    logic [31:0] b;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.A     = '0;
    bus.B     = '0;
    @(negedge clk);
    @(negedge clk);
    expect_reset_state("reset");
    @(negedge clk);
    reset     = 1'b0;
    next_free = cyc;

    issue("mult_neg", MD_MULT, 32'd3, 32'hFFFF_FFFC);
    issue("divu_7_2", MD_DIVU, 32'd7, 32'd2);
    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    issue("mthi", MD_MTHI, 32'h11, 32'd0);
    issue("mtlo", MD_MTLO, 32'h22, 32'd0);
    issue("div_zero", MD_DIV, 32'd1234, 32'd0);
    issue("divu_zero", MD_DIVU, 32'hFFFF_FFFF, 32'd0);
    issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    poke(MD_MTHI, 32'd5, 32'd0);
    issue("mthi_b2b", MD_MTHI, 32'd5, 32'd0);
    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue("mult_b2b", MD_MULT, 32'h8000_0000, 32'h8000_0000);
    issue("undef6", md_op_t'(6), 32'hDEAD_BEEF, 32'd1);
    issue("undef7", md_op_t'(7), 32'hCAFE_F00D, 32'd2);

    // Abort a DIV in its third busy cycle, then restart at once.
    issue("div_abort", MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    expect_reset_state("reset_abort");
    @(negedge clk);
    reset     = 1'b0;
    next_free = cyc;
    issue("after_reset", MD_MULTU, 32'h0001_0000, 32'h0001_0000);

    for (int i = 0; i < 40; i++) begin
      o = md_op_t'($urandom_range(0, 7));
      a = pick();
      b = pick();
      wait_free();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($sformatf("rand%0d_op%0d", i, o), o, a, b);
      if ((is_mul_op(o) || is_div_op(o)) && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        poke(md_op_t'($urandom_range(0, 7)), $urandom, $urandom);
      end
    end

    for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
